// File: rtl/daq_gearbox_fifo.sv
// ---------------------------------------------------------------------------
// daq_gearbox_fifo
//
// Single-clock width-down-converting FIFO. Each written sample is
// RATIO*RD_WIDTH bits wide and is read back as RATIO consecutive RD_WIDTH-bit
// words on a show-ahead port. Lane order is chosen by MSB_FIRST.
//
// Parameters
//   RD_WIDTH      read word width in bits
//   RATIO         read words per written sample (>= 2)
//   ADDRESS_WIDTH log2 of the depth in wide entries
//   MSB_FIRST     1: lane 0 is the most significant RD_WIDTH bits of a sample
//                 0: lane 0 is the least significant RD_WIDTH bits
//
// Ports
//   clk        single clock, rising edge
//   clear      asynchronous active-high reset of pointers, lane select, flags
//   flush      synchronous empty of pointers, lane select and flags
//   data       write sample (WR_WIDTH bits)
//   wrreq      write request, accepted when not full
//   wrfull     no free wide entry
//   q          current head read word, 0 while empty
//   rdreq      consume current q, accepted when not empty
//   rdempty    no read word available
//   rdusedw    read words available
//   overflow   sticky: write attempted while full
//   underflow  sticky: read attempted while empty
// ---------------------------------------------------------------------------
module daq_gearbox_fifo #(
  parameter int RD_WIDTH      = 8,
  parameter int RATIO         = 2,
  parameter int ADDRESS_WIDTH = 6,
  parameter bit MSB_FIRST     = 1'b1,
  localparam int WR_WIDTH     = RATIO * RD_WIDTH,
  localparam int USEDW_WIDTH  = ADDRESS_WIDTH + $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   flush,
  input  logic [WR_WIDTH-1:0]    data,
  input  logic                   wrreq,
  output logic                   wrfull,
  output logic [RD_WIDTH-1:0]    q,
  input  logic                   rdreq,
  output logic                   rdempty,
  output logic [USEDW_WIDTH-1:0] rdusedw,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int FIFO_DEPTH = 1 << ADDRESS_WIDTH;
  localparam int SEL_WIDTH  = $clog2(RATIO);

  localparam logic [ADDRESS_WIDTH:0] PTR_ONE    = (ADDRESS_WIDTH + 1)'(1);
  localparam logic [ADDRESS_WIDTH:0] DEPTH_CNT  = (ADDRESS_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [SEL_WIDTH-1:0]   SEL_ONE    = SEL_WIDTH'(1);
  localparam logic [SEL_WIDTH-1:0]   SEL_LAST   = SEL_WIDTH'(RATIO - 1);
  localparam logic [USEDW_WIDTH-1:0] RATIO_USED = USEDW_WIDTH'(RATIO);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [WR_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [ADDRESS_WIDTH:0]   r_wptr;
  logic [ADDRESS_WIDTH:0]   r_rptr;
  logic [SEL_WIDTH-1:0]     r_sel;
  logic                     r_overflow;
  logic                     r_underflow;

  // -------------------------------------------------------------------------
  // Derived status
  // -------------------------------------------------------------------------
  logic [ADDRESS_WIDTH:0]   w_wcnt;
  logic                     w_wrfull;
  logic                     w_rdempty;
  logic                     w_wr_ok;
  logic                     w_rd_ok;
  logic                     w_last_lane;
  logic [WR_WIDTH-1:0]      w_head;
  logic [RD_WIDTH-1:0]      w_lanes [RATIO];
  logic [USEDW_WIDTH-1:0]   w_wcnt_words;
  logic [USEDW_WIDTH-1:0]   w_sel_ext;

  // The extra wrap bit on each pointer makes the plain difference a valid
  // occupancy in 0..FIFO_DEPTH, including across wrap-around.
  assign w_wcnt      = r_wptr - r_rptr;
  assign w_wrfull    = (w_wcnt == DEPTH_CNT);
  assign w_rdempty   = (w_wcnt == '0);
  assign w_last_lane = (r_sel == SEL_LAST);

  // flush wins over both requests in the same cycle.
  assign w_wr_ok = wrreq & ~w_wrfull  & ~flush;
  assign w_rd_ok = rdreq & ~w_rdempty & ~flush;

  // A partially consumed head entry still counts as a full wide entry in
  // w_wcnt; the lanes already read are subtracted to get the word count.
  assign w_wcnt_words = USEDW_WIDTH'(w_wcnt) * RATIO_USED;
  assign w_sel_ext    = USEDW_WIDTH'(r_sel);

  // -------------------------------------------------------------------------
  // Show-ahead read path: split the head entry into lanes, pick lane r_sel.
  // -------------------------------------------------------------------------
  assign w_head = r_mem[r_rptr[ADDRESS_WIDTH-1:0]];

  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    localparam int LANE_LSB = MSB_FIRST ? (RATIO - 1 - k) * RD_WIDTH : k * RD_WIDTH;
    assign w_lanes[k] = w_head[LANE_LSB +: RD_WIDTH];
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // NOTE: the memory array has no reset; the read path masks q while empty,
  // so stale or uninitialised contents are never visible.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr[ADDRESS_WIDTH-1:0]] <= data;
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, lane select and sticky flags
  // -------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments so every
  // decision in this block uses the values from before the edge.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_sel       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_sel       <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        // The wide slot is released only when its last lane is consumed.
        if (w_last_lane) begin
          r_sel  <= '0;
          r_rptr <= r_rptr + PTR_ONE;
        end else begin
          r_sel  <= r_sel + SEL_ONE;
        end
      end
      if (wrreq && w_wrfull) begin
        r_overflow <= 1'b1;
      end
      if (rdreq && w_rdempty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wrfull    = w_wrfull;
  assign rdempty   = w_rdempty;
  assign rdusedw   = w_wcnt_words - w_sel_ext;
  assign q         = w_rdempty ? '0 : w_lanes[r_sel];
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/daq_gearbox_fifo.md
# daq_gearbox_fifo

Single-clock, parametrised width-down-converting FIFO between the DAQ sample path and the USB FIFO interface. It accepts `RATIO*RD_WIDTH`-bit samples on the write port and presents them as `RATIO` consecutive `RD_WIDTH`-bit words on a show-ahead read port, with configurable lane order. It adds word-level occupancy, synchronous flush, and sticky overflow/underflow flags, replacing the 16→8 bit DAQ FIFO for any width ratio and depth.

## Interface
- `RD_WIDTH`, 8, read word width in bits
- `RATIO`, 2, read words per written sample (≥2); write width `WR_WIDTH = RATIO*RD_WIDTH`
- `ADDRESS_WIDTH`, 6, log2 of depth in wide entries; `FIFO_DEPTH = 1<<ADDRESS_WIDTH`
- `MSB_FIRST`, 1, 1: lane 0 = `data[WR_WIDTH-1 -: RD_WIDTH]`; 0: lane 0 = `data[RD_WIDTH-1:0]`
- `clk`  in  1  single clock; all logic on rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous empty of FIFO and flags
- `data`  in  WR_WIDTH  write sample
- `wrreq`  in  1  write request
- `wrfull`  out  1  no free wide entry
- `q`  out  RD_WIDTH  current head read word (show-ahead)
- `rdreq`  in  1  consume current `q`
- `rdempty`  out  1  no read word available
- `rdusedw`  out  ADDRESS_WIDTH+clog2(RATIO)+1  read words available
- `overflow`  out  1  sticky: write attempted while full
- `underflow`  out  1  sticky: read attempted while empty

## Operation
- Storage: `FIFO_DEPTH` entries of `WR_WIDTH` bits; write/read pointers `ADDRESS_WIDTH+1` bits (extra wrap bit); wide count `wcnt = wptr - rptr` (0..FIFO_DEPTH).
- Lane select `sel` (0..RATIO-1) indexes the head entry; `q` = lane `sel` of `mem[rptr]` per `MSB_FIRST`; `q` = 0 when `rdempty`.
- Write accepted iff `wrreq && !wrfull`: `mem[wptr] <= data`, `wptr++`.
- Read accepted iff `rdreq && !rdempty`: if `sel == RATIO-1` then `sel <= 0`, `rptr++`; else `sel++`.
- `wrfull = (wcnt == FIFO_DEPTH)`; `rdempty = (wcnt == 0)`; `rdusedw = wcnt*RATIO - sel`.
- A partially consumed head entry still occupies its slot; its space is freed only when its last lane is read.
- `overflow` set on `wrreq && wrfull`; `underflow` set on `rdreq && rdempty`; held until `clear` or `flush`. A rejected access changes no pointer, `sel` or memory.
- `flush` (synchronous): `wptr`, `rptr`, `sel`, `overflow` and `underflow` go to 0; takes priority over `wrreq`/`rdreq` in the same cycle. Memory contents are not cleared.
- `clear` (asynchronous): same register effect as `flush`, immediately, regardless of `clk`; any half-read entry is discarded.

## Timing
- Reset values: `wrfull`=0, `rdempty`=1, `rdusedw`=0, `q`=0, `overflow`=0, `underflow`=0.
- Flags and `rdusedw` are combinational from registered pointers, so they update after the clock edge that changed the pointers.
- Write-to-read latency is 1 cycle: a sample written at edge N gives `rdempty`=0 and valid `q` (lane 0) after edge N.
- Read: `q` is valid while `rdempty`=0; the edge with `rdreq` consumes it, and the next lane appears after that edge. Back-to-back reads stream one word per cycle.
- Simultaneous write and read when neither is blocked: both take effect; `wcnt` changes by +1 (read on a non-last lane) or 0 (read on the last lane).
- Full with a last-lane read in the same cycle: the write is rejected (`wrfull` was 1 at the edge), `overflow` sets, and `wrfull` drops after the edge.
- Empty with a write and read in the same cycle: the read is rejected and `underflow` sets; the write is accepted.
- Pointer wrap-around at `FIFO_DEPTH` uses the wrap bit, with no lost or duplicated entries.

## Test plan
Default widths, `ADDRESS_WIDTH`=2.
- Reset/idle: assert `clear` mid-cycle with 2 entries queued → outputs go to reset values immediately, without a clock edge; `rdusedw`=0.
- Order, `MSB_FIRST`=1: write 0xA1B2, 0xC3D4, then read 4 → `q` = 0xA1, 0xB2, 0xC3, 0xD4; `rdempty`=1 after the 4th read. With `MSB_FIRST`=0 → 0xB2, 0xA1, 0xD4, 0xC3.
- Full/overflow: write 5 samples → `wrfull`=1 after the 4th write, 5th is dropped, `overflow`=1, `rdusedw`=8; read all 8 → only the first 4 samples are returned.
- Simultaneous at full: with 4 entries and `sel`=1, issue `wrreq`+`rdreq` together → read accepted, write rejected, `overflow`=1, `wrfull`=0 and `rdusedw`=6 afterwards.
- Underflow and flush: `rdreq` on empty → `underflow`=1, `q`=0. Then write 2 entries and pulse `flush` together with `wrreq` → `rdempty`=1, `rdusedw`=0, both flags 0, write discarded.
- Wrap and stream: 20 samples with random `wrreq`/`rdreq` throttling → read stream equals the scoreboard, and `rdusedw` matches the model on every cycle.
